// File: rtl/adc_uart_dump_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_uart_dump_if
// Description : Bundle of the frame-dump control, sample RAM read port and
//               UART serial line. Signal names follow the dump block's own
//               direction: i_* flow into the dump block, o_* flow out of it.
//   i_start     1   begin-frame pulse
//   o_busy      1   frame in progress
//   o_done      1   end-of-frame pulse
//   o_rd_addr   8   sample RAM read address
//   i_rd_data   12  sample RAM read data (one cycle behind the address)
//   o_uart_tx   1   8N1 serial output, idle high
//   Modports    : master = controller/RAM side, slave = dump block
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_uart_dump_if;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_rd_addr;
    logic [11:0] i_rd_data;
    logic        o_uart_tx;

    modport master (
        output i_start,
        output i_rd_data,
        input  o_busy,
        input  o_done,
        input  o_rd_addr,
        input  o_uart_tx
    );

    modport slave (
        input  i_start,
        input  i_rd_data,
        output o_busy,
        output o_done,
        output o_rd_addr,
        output o_uart_tx
    );
endinterface
`default_nettype wire

// File: rtl/adc_uart_dump.sv
`default_nettype none
// ============================================================================
// Module      : adc_uart_dump
// Description : After a start pulse, reads NUM_POINTS 12-bit samples from a
//               synchronous-read sample RAM and streams them over an 8N1 UART
//               as one binary frame:
//                 SYNC_BYTE, then per sample {4'h0,d[11:8]}, d[7:0]
//               in address order 0..NUM_POINTS-1.
// Ports       :
//   i_clk        1   system clock
//   i_rst        1   asynchronous active-high reset
//   bus          -   adc_uart_dump_if.slave (start/busy/done, RAM read port,
//                    UART tx line)
// Parameters  :
//   NUM_POINTS   samples per frame (1..256)
//   CLKS_PER_BIT i_clk cycles per UART bit
//   SYNC_BYTE    first byte of every frame
// Build option: define ADC_DUMP_CHECKSUM_EN to append one byte holding the
//               mod-256 sum of all sample bytes (sync byte excluded).
// Revision    : 1.0 - initial release
// ============================================================================
module adc_uart_dump #(
    parameter int         NUM_POINTS   = 200,
    parameter int         CLKS_PER_BIT = 217,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  wire            i_clk,
    input  wire            i_rst,
    adc_uart_dump_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]          c_LAST_IDX  = 8'(NUM_POINTS - 1);
    // Bit slots within a UART character: 0 = start, 1..8 = data, 9 = stop.
    localparam logic [3:0]          c_STOP_SLOT = 4'd9;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_SEND_SYNC = 3'd1;
    localparam logic [2:0] c_ST_FETCH     = 3'd2;
    localparam logic [2:0] c_ST_WAIT_RD   = 3'd3;
    localparam logic [2:0] c_ST_SEND_HI   = 3'd4;
    localparam logic [2:0] c_ST_SEND_LO   = 3'd5;
    localparam logic [2:0] c_ST_FINISH    = 3'd6;
`ifdef ADC_DUMP_CHECKSUM_EN
    localparam logic [2:0] c_ST_SEND_CSUM = 3'd7;
`endif

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [2:0]          w_state_next;

    logic [7:0]          r_rd_addr;     // doubles as the sample index
    logic [11:0]         r_sample;

    logic                r_tx_active;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [3:0]          r_bit_cnt;
    logic [8:0]          r_tx_shift;    // remaining data bits followed by stop bit
    logic                r_tx_line;

    logic                w_tx_done;
    logic                w_tx_load;
    logic [7:0]          w_tx_byte;
    logic                w_busy;
    logic                w_done;
    logic                w_last_sample;

`ifdef ADC_DUMP_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    // Stop bit of the current character is in its final clock.
    assign w_tx_done     = r_tx_active && (r_bit_cnt == c_STOP_SLOT) && (r_baud_cnt == c_BAUD_LAST);
    assign w_last_sample = (r_rd_addr == c_LAST_IDX);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // Every SEND_* state leaves on the same edge the stop bit ends, so the
    // following character can be launched on the very next cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.i_start) begin
                    w_state_next = c_ST_SEND_SYNC;
                end
            end
            c_ST_SEND_SYNC: begin
                if (w_tx_done) begin
                    w_state_next = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_state_next = c_ST_WAIT_RD;
            end
            c_ST_WAIT_RD: begin
                w_state_next = c_ST_SEND_HI;
            end
            c_ST_SEND_HI: begin
                if (w_tx_done) begin
                    w_state_next = c_ST_SEND_LO;
                end
            end
            c_ST_SEND_LO: begin
                if (w_tx_done) begin
                    if (w_last_sample) begin
`ifdef ADC_DUMP_CHECKSUM_EN
                        w_state_next = c_ST_SEND_CSUM;
`else
                        w_state_next = c_ST_FINISH;
`endif
                    end else begin
                        w_state_next = c_ST_FETCH;
                    end
                end
            end
`ifdef ADC_DUMP_CHECKSUM_EN
            c_ST_SEND_CSUM: begin
                if (w_tx_done) begin
                    w_state_next = c_ST_FINISH;
                end
            end
`endif
            c_ST_FINISH: begin
                // i_start is deliberately not looked at here.
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // The shifter is loaded on the first cycle of a SEND_* state, i.e. while
    // the transmitter is still idle; it goes active on the following edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy    = 1'b1;
        w_done    = 1'b0;
        w_tx_load = 1'b0;
        w_tx_byte = 8'h00;
        case (r_state)
            c_ST_IDLE: begin
                w_busy = 1'b0;
            end
            c_ST_SEND_SYNC: begin
                w_tx_load = !r_tx_active;
                w_tx_byte = SYNC_BYTE;
            end
            c_ST_SEND_HI: begin
                w_tx_load = !r_tx_active;
                w_tx_byte = {4'h0, r_sample[11:8]};
            end
            c_ST_SEND_LO: begin
                w_tx_load = !r_tx_active;
                w_tx_byte = r_sample[7:0];
            end
`ifdef ADC_DUMP_CHECKSUM_EN
            c_ST_SEND_CSUM: begin
                w_tx_load = !r_tx_active;
                w_tx_byte = r_csum;
            end
`endif
            c_ST_FINISH: begin
                w_busy = 1'b0;
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read address / sample capture
    // The address is updated on the edge that enters FETCH so it is on the
    // bus during FETCH; the synchronous RAM presents data during WAIT_RD,
    // which is captured on the edge leaving WAIT_RD. Outside these updates
    // the address holds.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_addr <= 8'h00;
            r_sample  <= 12'h000;
        end else begin
            if ((r_state == c_ST_SEND_SYNC) && w_tx_done) begin
                r_rd_addr <= 8'h00;
            end else if ((r_state == c_ST_SEND_LO) && w_tx_done && !w_last_sample) begin
                r_rd_addr <= r_rd_addr + 8'd1;
            end

            if (r_state == c_ST_WAIT_RD) begin
                r_sample <= bus.i_rd_data;
            end
        end
    end

`ifdef ADC_DUMP_CHECKSUM_EN
    // ------------------------------------------------------------------------
    // Running mod-256 sum of both bytes of every sample.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_csum <= 8'h00;
        end else if ((r_state == c_ST_IDLE) && bus.i_start) begin
            r_csum <= 8'h00;
        end else if (r_state == c_ST_WAIT_RD) begin
            r_csum <= r_csum + {4'h0, bus.i_rd_data[11:8]} + bus.i_rd_data[7:0];
        end
    end
`endif

    // ------------------------------------------------------------------------
    // UART transmitter (8N1, LSB first)
    // r_tx_line is registered so the serial output is glitch free. On load
    // it drops to the start bit; each bit boundary shifts the next slot out.
    // After the stop slot the line simply stays high.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_active <= 1'b0;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= 4'd0;
            r_tx_shift  <= 9'h1FF;
            r_tx_line   <= 1'b1;
        end else if (w_tx_load) begin
            r_tx_active <= 1'b1;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= 4'd0;
            r_tx_shift  <= {1'b1, w_tx_byte};
            r_tx_line   <= 1'b0;
        end else if (r_tx_active) begin
            if (r_baud_cnt == c_BAUD_LAST) begin
                r_baud_cnt <= '0;
                if (r_bit_cnt == c_STOP_SLOT) begin
                    r_tx_active <= 1'b0;
                    r_bit_cnt   <= 4'd0;
                end else begin
                    r_bit_cnt  <= r_bit_cnt + 4'd1;
                    r_tx_line  <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------------
    assign bus.o_busy    = w_busy;
    assign bus.o_done    = w_done;
    assign bus.o_rd_addr = r_rd_addr;
    assign bus.o_uart_tx = r_tx_line;

endmodule
`default_nettype wire

// File: tb/tb_adc_uart_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_uart_dump
// Description : Self-checking bench for adc_uart_dump. Expected frame bytes
//               are queued when a frame is started and popped as the UART
//               decoder recovers each character. Instances: 4 points and
//               1 point (plus 200 points with ADC_DUMP_CHECKSUM_EN), all at
//               4 clocks per bit; one is selected at a time through sel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_uart_dump;
    localparam int CPB = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic start  = 1'b0;
    logic glitch = 1'b0;
    logic log_en = 1'b0;
    int   sel    = 0;

    int   n_pass      = 0;
    int   n_total     = 0;
    int   done_cnt    = 0;
    int   frame_done0 = 0;

    logic [7:0] exp_q[$];
    logic [7:0] addr_log[$];

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // DUT instances
    // ------------------------------------------------------------------------
    adc_uart_dump_if if4();
    adc_uart_dump_if if1();

    adc_uart_dump #(.NUM_POINTS(4), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) u_dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if4)
    );
    adc_uart_dump #(.NUM_POINTS(1), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) u_dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if1)
    );

    assign if4.i_start = start && (sel == 0);
    assign if1.i_start = start && (sel == 1);

    // Synchronous-read RAM models returning 12'hA00+addr. With glitch set the
    // 4-point model only returns valid data in the one cycle after an address
    // change and garbage otherwise.
    logic [7:0] a4_q = 8'h00;
    always @(posedge clk) begin
        a4_q <= if4.o_rd_addr;
        if4.i_rd_data <= (!glitch || (if4.o_rd_addr != a4_q)) ?
                         (12'hA00 + {4'h0, if4.o_rd_addr}) : 12'h5A5;
    end
    always @(posedge clk) begin
        if1.i_rd_data <= 12'hA00 + {4'h0, if1.o_rd_addr};
    end

`ifdef ADC_DUMP_CHECKSUM_EN
    adc_uart_dump_if if200();
    adc_uart_dump #(.NUM_POINTS(200), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) u_dut200 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if200)
    );
    assign if200.i_start   = start && (sel == 2);
    assign if200.i_rd_data = 12'hFFF;
`endif

    // ------------------------------------------------------------------------
    // Selected-instance view and monitors
    // ------------------------------------------------------------------------
    logic       m_tx;
    logic       m_busy;
    logic       m_done;
    logic [7:0] m_addr;
    logic [7:0] m_addr_q = 8'h00;

    always_comb begin
        m_tx   = if4.o_uart_tx;
        m_busy = if4.o_busy;
        m_done = if4.o_done;
        m_addr = if4.o_rd_addr;
        if (sel == 1) begin
            m_tx   = if1.o_uart_tx;
            m_busy = if1.o_busy;
            m_done = if1.o_done;
            m_addr = if1.o_rd_addr;
        end
`ifdef ADC_DUMP_CHECKSUM_EN
        else if (sel == 2) begin
            m_tx   = if200.o_uart_tx;
            m_busy = if200.o_busy;
            m_done = if200.o_done;
            m_addr = if200.o_rd_addr;
        end
`endif
    end

    always @(posedge clk) begin
        m_addr_q <= m_addr;
        if (m_done === 1'b1) done_cnt <= done_cnt + 1;
        if (log_en && (m_addr !== m_addr_q)) addr_log.push_back(m_addr);
    end

    // ------------------------------------------------------------------------
    // Scoreboard feed: whole expected frame for the selected instance
    // ------------------------------------------------------------------------
    task automatic push_expected();
        int         np;
        logic [11:0] d;
        logic [7:0]  cs;
        np = (sel == 0) ? 4 : (sel == 1) ? 1 : 200;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int a = 0; a < np; a++) begin
            d = (sel == 2) ? 12'hFFF : (12'hA00 + 12'(a));
            exp_q.push_back({4'h0, d[11:8]});
            exp_q.push_back(d[7:0]);
            cs = cs + {4'h0, d[11:8]} + d[7:0];
        end
`ifdef ADC_DUMP_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    // UART character decoder sampling on falling edges. ok drops if any bit
    // is not steady for exactly CPB samples or framing bits are wrong; gap
    // is the number of idle samples before the start bit.
    task automatic rx_byte(output logic [7:0] b, output int gap, output bit ok);
        logic [9:0] bits;
        int         w;
        ok  = 1'b1;
        b   = 8'h00;
        w   = 0;
        while (m_tx !== 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        gap = w;
        if (m_tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        for (int i = 0; i < 10; i++) begin
            bits[i] = m_tx;
            for (int c = 1; c < CPB; c++) begin
                @(negedge clk);
                if (m_tx !== bits[i]) ok = 1'b0;
            end
            @(negedge clk);
        end
        b = bits[8:1];
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    endtask

    // Called on a falling edge: queue the frame and pulse i_start.
    task automatic start_frame(input string name);
        push_expected();
        frame_done0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (m_busy !== 1'b1) $display("FAIL %s busy_after_start: got %b expected 1", name, m_busy);
        else n_pass++;
    endtask

    // Receive everything queued, then wait for o_done; returns on the falling
    // edge inside the o_done cycle.
    task automatic recv_frame(input string name);
        logic [7:0] b;
        logic [7:0] e;
        int         gap;
        bit         ok;
        int         n;
        int         w;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            rx_byte(b, gap, ok);
            e = exp_q.pop_front();
            n_total++;
            if (b !== e || !ok)
                $display("FAIL %s byte%0d: got %02h bit_timing_ok=%0d expected %02h bit_timing_ok=1", name, k, b, ok, e);
            else n_pass++;
            if (k > 0) begin
                n_total++;
                if (gap > 3) $display("FAIL %s gap_before_byte%0d: got %0d cycles expected <=3", name, k, gap);
                else n_pass++;
            end
        end
        w = 0;
        while (m_done !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_total++;
        if (m_done !== 1'b1 || m_busy !== 1'b0)
            $display("FAIL %s done_cycle: got done=%b busy=%b expected done=1 busy=0", name, m_done, m_busy);
        else n_pass++;
    endtask

    // After o_done: line stays idle (no extra byte) and exactly one pulse.
    task automatic post_frame(input string name);
        int lows;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (m_tx !== 1'b1) lows++;
        end
        n_total++;
        if (lows != 0) $display("FAIL %s idle_after_frame: got %0d low samples expected 0", name, lows);
        else n_pass++;
        n_total++;
        if (done_cnt - frame_done0 != 1)
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - frame_done0);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        sel = 0;
        repeat (3) @(negedge clk);
        n_total++;
        if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0 || m_addr !== 8'h00)
            $display("FAIL reset_state: got tx=%b busy=%b done=%b addr=%02h expected 1 0 0 00", m_tx, m_busy, m_done, m_addr);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int w;
        int d0;
        int lows;
        sel = 0;
        frame_done0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        w = 0;
        while (m_tx !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0)
            $display("FAIL midframe_reset: got tx=%b busy=%b done=%b expected 1 0 0", m_tx, m_busy, m_done);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (m_tx !== 1'b1 || m_busy !== 1'b0) lows++;
        end
        n_total++;
        if (lows != 0 || done_cnt != d0 || m_addr !== 8'h00)
            $display("FAIL after_reset_quiet: got active=%0d done_pulses=%0d addr=%02h expected 0 0 00", lows, done_cnt - d0, m_addr);
        else n_pass++;
    endtask

    task automatic test_frame();
        sel = 0;
        start_frame("frame");
        recv_frame("frame");
        post_frame("frame");
    endtask

    task automatic test_read_timing();
        sel = 0;
        addr_log.delete();
        glitch = 1'b1;
        log_en = 1'b1;
        start_frame("read_timing");
        recv_frame("read_timing");
        post_frame("read_timing");
        glitch = 1'b0;
        log_en = 1'b0;
        n_total++;
        if (addr_log.size() != 4) $display("FAIL addr_steps_count: got %0d expected 4", addr_log.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            n_total++;
            if (addr_log[i] !== 8'(i)) $display("FAIL addr_step%0d: got %02h expected %02h", i, addr_log[i], 8'(i));
            else n_pass++;
        end
    endtask

    task automatic test_busy_guard();
        sel = 0;
        start_frame("busy_guard");
        fork
            begin
                repeat (145) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        recv_frame("busy_guard");
        post_frame("busy_guard");
    endtask

    task automatic test_back_to_back();
        sel = 0;
        start_frame("b2b_first");
        recv_frame("b2b_first");
        // Start held across the o_done cycle and the following IDLE cycle.
        start = 1'b1;
        push_expected();
        @(negedge clk);
        frame_done0 = done_cnt;
        n_total++;
        if (m_busy !== 1'b0) $display("FAIL b2b_start_on_done: got busy=%b expected 0", m_busy);
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (m_busy !== 1'b1) $display("FAIL b2b_start_after_done: got busy=%b expected 1", m_busy);
        else n_pass++;
        recv_frame("b2b_second");
        post_frame("b2b_second");
    endtask

    task automatic test_single_point();
        sel = 1;
        @(negedge clk);
        start_frame("single_point");
        recv_frame("single_point");
        post_frame("single_point");
        sel = 0;
        @(negedge clk);
    endtask

`ifdef ADC_DUMP_CHECKSUM_EN
    task automatic test_full_checksum();
        sel = 2;
        @(negedge clk);
        start_frame("full_csum");
        recv_frame("full_csum");
        post_frame("full_csum");
        sel = 0;
        @(negedge clk);
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_midframe();
        test_frame();
        test_read_timing();
        test_busy_guard();
        test_back_to_back();
        test_single_point();
`ifdef ADC_DUMP_CHECKSUM_EN
        test_full_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
